// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
package dpram_arb_pkg;

  function automatic int calc_aw(input int mem_length);
    return (mem_length > 1) ? $clog2(mem_length) : 1;
  endfunction

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Tag id is sized for up to 256 requesters so the struct does not depend on NUM_REQ.
  localparam int ID_W = 8;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/dual_port_ram_arbiter_if.sv
// Client request/response bus plus the RAM port pins of the dual-port RAM arbiter.
interface dual_port_ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_LENGTH = 64
);
  localparam int AW = dpram_arb_pkg::calc_aw(MEM_LENGTH);
  localparam int DW = DATA_WIDTH;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [NUM_REQ*DW-1:0] rdata;

  logic          ram_wen_a,   ram_wen_b;
  logic [AW-1:0] ram_waddr_a, ram_waddr_b;
  logic [AW-1:0] ram_raddr_a, ram_raddr_b;
  logic [DW-1:0] ram_wdata_a, ram_wdata_b;
  logic [DW-1:0] ram_rdata_a, ram_rdata_b;

  modport slave (
    input  req, we, addr, wdata, ram_rdata_a, ram_rdata_b,
    output gnt, rvalid, rdata,
    output ram_wen_a, ram_wen_b, ram_waddr_a, ram_waddr_b,
    output ram_raddr_a, ram_raddr_b, ram_wdata_a, ram_wdata_b
  );

  modport master (
    output req, we, addr, wdata, ram_rdata_a, ram_rdata_b,
    input  gnt, rvalid, rdata,
    input  ram_wen_a, ram_wen_b, ram_waddr_a, ram_waddr_b,
    input  ram_raddr_a, ram_raddr_b, ram_wdata_a, ram_wdata_b
  );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority finder: first unmasked requester at or after start, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);
  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j] && !mask[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Shares one dual-port RAM between NUM_REQ clients: two round-robin grants per cycle,
// RAM pins driven directly, read data routed back to the issuing client one cycle later.
module dual_port_ram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_LENGTH = 64
) (
  input logic clk,
  input logic rst,
  dual_port_ram_arbiter_if.slave bus
);
  localparam int AW = calc_aw(MEM_LENGTH);
  localparam int DW = DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  logic [IW-1:0]      rr_ptr, a_idx, b_idx, b_start, last_idx;
  logic               a_found, b_raw_found, wr_conflict;
  logic [NUM_REQ-1:0] b_mask;
  logic [AW-1:0]      c_addr  [NUM_REQ];
  logic [DW-1:0]      c_wdata [NUM_REQ];
  logic               grant_v [2];
  logic [IW-1:0]      grant_i [2];
  logic               p_wen   [2];
  logic [AW-1:0]      p_waddr [2];
  logic [AW-1:0]      p_raddr [2];
  logic [DW-1:0]      p_wdata [2];
  logic [DW-1:0]      port_rdata [2];
  tag_t               tag_q   [2];
  logic [DW-1:0]      rdata_q [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_n, rvalid_n;
  logic [NUM_REQ*DW-1:0] rdata_n;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      c_addr[i]  = bus.addr[i*AW +: AW];
      c_wdata[i] = bus.wdata[i*DW +: DW];
    end
  end

  // Port B continues the same scan just past the A winner, never re-picking it.
  assign b_start = inc_wrap(a_idx);
  assign b_mask  = a_found ? (NUM_REQ'(1) << a_idx) : '0;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
    .req(bus.req), .start(rr_ptr), .mask({NUM_REQ{1'b0}}), .found(a_found), .idx(a_idx)
  );

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
    .req(bus.req), .start(b_start), .mask(b_mask), .found(b_raw_found), .idx(b_idx)
  );

  assign wr_conflict = a_found && b_raw_found && bus.we[a_idx] && bus.we[b_idx] &&
                       (c_addr[a_idx] == c_addr[b_idx]);

  always_comb begin
    grant_v[PORT_A] = rst && a_found;
    grant_v[PORT_B] = rst && a_found && b_raw_found && !wr_conflict;
    grant_i[PORT_A] = a_idx;
    grant_i[PORT_B] = b_idx;
  end

  always_comb begin
    gnt_n = '0;
    for (int p = 0; p < 2; p++) begin
      p_wen[p]   = 1'b0;
      p_waddr[p] = '0;
      p_raddr[p] = '0;
      p_wdata[p] = '0;
      if (grant_v[p]) begin
        gnt_n[grant_i[p]] = 1'b1;
        if (bus.we[grant_i[p]]) begin
          p_wen[p]   = 1'b1;
          p_waddr[p] = c_addr[grant_i[p]];
          p_wdata[p] = c_wdata[grant_i[p]];
        end else begin
          p_raddr[p] = c_addr[grant_i[p]];
        end
      end
    end
  end

  assign bus.gnt         = gnt_n;
  assign bus.ram_wen_a   = p_wen[PORT_A];
  assign bus.ram_wen_b   = p_wen[PORT_B];
  assign bus.ram_waddr_a = p_waddr[PORT_A];
  assign bus.ram_waddr_b = p_waddr[PORT_B];
  assign bus.ram_raddr_a = p_raddr[PORT_A];
  assign bus.ram_raddr_b = p_raddr[PORT_B];
  assign bus.ram_wdata_a = p_wdata[PORT_A];
  assign bus.ram_wdata_b = p_wdata[PORT_B];

  assign last_idx = grant_v[PORT_B] ? b_idx : a_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_v[PORT_A]) begin
      rr_ptr <= inc_wrap(last_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q[PORT_A] <= '0;
      tag_q[PORT_B] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        tag_q[p] <= '{valid: grant_v[p] && !bus.we[grant_i[p]], id: ID_W'(grant_i[p])};
      end
    end
  end

  assign port_rdata[PORT_A] = bus.ram_rdata_a;
  assign port_rdata[PORT_B] = bus.ram_rdata_b;

  // The RAM output register lines up with the tags, so data is steered straight through.
  always_comb begin
    rvalid_n = '0;
    rdata_n  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdata_n[i*DW +: DW] = rdata_q[i];
      for (int p = 0; p < 2; p++) begin
        if (tag_q[p].valid && (tag_q[p].id == ID_W'(i))) begin
          rvalid_n[i]         = 1'b1;
          rdata_n[i*DW +: DW] = port_rdata[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rvalid_n[i]) rdata_q[i] <= rdata_n[i*DW +: DW];
      end
    end
  end

  assign bus.rvalid = rvalid_n;
  assign bus.rdata  = rdata_n;
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Self-checking bench: behavioural RAM plus a scan-order reference model of the arbiter.
module tb_dual_port_ram_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int ML = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MEM_LENGTH(ML)) bus ();
  dual_port_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MEM_LENGTH(ML)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // RAM: registered read-before-write outputs, synchronous reset (memory cleared too).
  logic [DW-1:0] ram [ML];
  always @(posedge clk) begin
    if (!rst) begin
      bus.ram_rdata_a <= '0;
      bus.ram_rdata_b <= '0;
      for (int i = 0; i < ML; i++) ram[i] <= '0;
    end else begin
      bus.ram_rdata_a <= ram[bus.ram_raddr_a];
      bus.ram_rdata_b <= ram[bus.ram_raddr_b];
      if (bus.ram_wen_a) ram[bus.ram_waddr_a] <= bus.ram_wdata_a;
      if (bus.ram_wen_b) ram[bus.ram_waddr_b] <= bus.ram_wdata_b;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  logic          c_req [NR];
  logic          c_we  [NR];
  logic [AW-1:0] c_addr[NR];
  logic [DW-1:0] c_wdata[NR];

  int            m_ptr;
  logic [DW-1:0] m_mem [ML];
  logic          m_pv  [2];
  int            m_pid [2];
  logic [DW-1:0] m_pd  [2];
  logic [DW-1:0] m_rd  [NR];
  logic          m_known[NR];
  int            wait_cnt[NR];

  int            e_win [2];
  logic [NR-1:0] e_gnt, e_rvalid;
  logic [DW-1:0] e_rdata[NR];
  logic          e_chk [NR];
  logic          e_wen [2];
  logic [AW-1:0] e_waddr[2], e_raddr[2];
  logic [DW-1:0] e_wdata[2];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]            = c_req[i];
      bus.we[i]             = c_we[i];
      bus.addr[i*AW +: AW]  = c_addr[i];
      bus.wdata[i*DW +: DW] = c_wdata[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) c_req[i] = 1'b0;
    drive();
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_pv[0] = 1'b0;
    m_pv[1] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_known[i] = 1'b0;
      m_rd[i] = '0;
    end
    for (int a = 0; a < ML; a++) m_mem[a] = '0;
  endtask

  task automatic model_predict();
    int a = -1;
    int b = -1;
    e_gnt = '0;
    e_rvalid = '0;
    for (int i = 0; i < NR; i++) begin
      e_rdata[i] = m_rd[i];
      e_chk[i] = m_known[i];
    end
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        int j = (m_ptr + k) % NR;
        if (c_req[j]) begin
          if (a < 0) a = j;
          else if (b < 0) b = j;
        end
      end
      if (a >= 0 && b >= 0 && c_we[a] && c_we[b] && c_addr[a] == c_addr[b]) b = -1;
      for (int p = 0; p < 2; p++) begin
        if (m_pv[p]) begin
          e_rvalid[m_pid[p]] = 1'b1;
          e_rdata[m_pid[p]] = m_pd[p];
          e_chk[m_pid[p]] = 1'b1;
        end
      end
    end
    e_win[0] = a;
    e_win[1] = b;
    for (int p = 0; p < 2; p++) begin
      e_wen[p] = 1'b0;
      e_waddr[p] = '0;
      e_raddr[p] = '0;
      e_wdata[p] = '0;
      if (e_win[p] >= 0) begin
        e_gnt[e_win[p]] = 1'b1;
        if (c_we[e_win[p]]) begin
          e_wen[p] = 1'b1;
          e_waddr[p] = c_addr[e_win[p]];
          e_wdata[p] = c_wdata[e_win[p]];
        end else begin
          e_raddr[p] = c_addr[e_win[p]];
        end
      end
    end
  endtask

  task automatic model_commit();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if (m_pv[p]) begin
        m_rd[m_pid[p]] = m_pd[p];
        m_known[m_pid[p]] = 1'b1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      m_pv[p] = 1'b0;
      if (e_win[p] >= 0 && !c_we[e_win[p]]) begin
        m_pv[p] = 1'b1;
        m_pid[p] = e_win[p];
        m_pd[p] = m_mem[c_addr[e_win[p]]];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (e_win[p] >= 0 && c_we[e_win[p]]) m_mem[c_addr[e_win[p]]] = c_wdata[e_win[p]];
    end
    if (e_win[1] >= 0) m_ptr = (e_win[1] + 1) % NR;
    else if (e_win[0] >= 0) m_ptr = (e_win[0] + 1) % NR;
  endtask

  task automatic sample();
    @(negedge clk);
    model_predict();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic r, input logic w,
                            input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    c_req[i] = r;
    c_we[i] = w;
    c_addr[i] = ad;
    c_wdata[i] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) set_client(i, 1'b1, 1'b0, AW'(i), '0);
    drive();
    repeat (2) begin
      sample();
      n_chk++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b expected 0000", bus.gnt); end
      n_chk++; if (bus.rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid got %b expected 0000", bus.rvalid); end
      n_chk++; if ({bus.ram_wen_a, bus.ram_wen_b} !== 2'b00) begin n_err++; $display("FAIL reset_wen got %b%b expected 00", bus.ram_wen_a, bus.ram_wen_b); end
      n_chk++; if ({bus.ram_raddr_a, bus.ram_raddr_b} !== '0) begin n_err++; $display("FAIL reset_raddr got %h %h expected 0 0", bus.ram_raddr_a, bus.ram_raddr_b); end
      advance();
    end
    rst = 1'b1;
    sample();
    n_chk++; if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL release_gnt got %b expected 0011", bus.gnt); end
    advance();
    clear_reqs();
  endtask

  task automatic test_write_read();
    set_client(0, 1'b1, 1'b1, 6'd5, 8'hA5);
    set_client(1, 1'b1, 1'b1, 6'd9, 8'h3C);
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL wr_gnt got %b expected 0011", bus.gnt); end
    advance();
    c_req[0] = 1'b0; c_req[1] = 1'b0;
    set_client(2, 1'b1, 1'b0, 6'd5, '0);
    set_client(3, 1'b1, 1'b0, 6'd9, '0);
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b1100) begin n_err++; $display("FAIL rd_gnt got %b expected 1100", bus.gnt); end
    advance();
    clear_reqs();
    sample();
    n_chk++; if (bus.rvalid !== 4'b1100) begin n_err++; $display("FAIL wr_rd_rvalid got %b expected 1100", bus.rvalid); end
    n_chk++; if (bus.rdata[2*DW +: DW] !== 8'hA5) begin n_err++; $display("FAIL wr_rd_rdata2 got %h expected a5", bus.rdata[2*DW +: DW]); end
    n_chk++; if (bus.rdata[3*DW +: DW] !== 8'h3C) begin n_err++; $display("FAIL wr_rd_rdata3 got %h expected 3c", bus.rdata[3*DW +: DW]); end
    advance();
  endtask

  task automatic test_conflict();
    set_client(0, 1'b1, 1'b1, 6'd7, 8'h11);
    set_client(1, 1'b1, 1'b1, 6'd7, 8'h22);
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL conflict_gnt0 got %b expected 0001", bus.gnt); end
    n_chk++; if (bus.ram_wen_b !== 1'b0) begin n_err++; $display("FAIL conflict_wen_b got %b expected 0", bus.ram_wen_b); end
    advance();
    c_req[0] = 1'b0;
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL conflict_gnt1 got %b expected 0010", bus.gnt); end
    n_chk++; if ({bus.ram_wen_a, bus.ram_wdata_a} !== {1'b1, 8'h22}) begin n_err++; $display("FAIL conflict_port_a got %b/%h expected 1/22", bus.ram_wen_a, bus.ram_wdata_a); end
    advance();
    c_req[1] = 1'b0;
    set_client(2, 1'b1, 1'b0, 6'd7, '0);
    set_client(3, 1'b1, 1'b0, 6'd7, '0);
    drive();
    sample();
    advance();
    clear_reqs();
    sample();
    n_chk++; if (bus.rvalid !== 4'b1100) begin n_err++; $display("FAIL conflict_rvalid got %b expected 1100", bus.rvalid); end
    n_chk++; if (bus.rdata[2*DW +: DW] !== 8'h22) begin n_err++; $display("FAIL conflict_rdata got %h expected 22", bus.rdata[2*DW +: DW]); end
    advance();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) set_client(i, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
      drive();
      sample();
      exp_g = (k % 2 == 0) ? 4'b0011 : 4'b1100;
      n_chk++; if (bus.gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt cycle %0d got %b expected %b", k, bus.gnt, exp_g); end
      if (k > 0) begin
        n_chk++; if (bus.rvalid !== ~exp_g) begin n_err++; $display("FAIL rr_rvalid cycle %0d got %b expected %b", k, bus.rvalid, ~exp_g); end
        for (int i = 0; i < NR; i++) begin
          if (e_rvalid[i]) begin
            n_chk++; if (bus.rdata[i*DW +: DW] !== e_rdata[i]) begin n_err++; $display("FAIL rr_rdata client %0d got %h expected %h", i, bus.rdata[i*DW +: DW], e_rdata[i]); end
          end
        end
      end
      advance();
    end
    clear_reqs();
    sample();
    n_chk++; if (bus.rvalid !== 4'b1100) begin n_err++; $display("FAIL rr_last_rvalid got %b expected 1100", bus.rvalid); end
    advance();
  endtask

  task automatic test_read_before_write();
    set_client(0, 1'b1, 1'b1, 6'd3, 8'h77);
    set_client(1, 1'b1, 1'b0, 6'd3, '0);
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b0011) begin n_err++; $display("FAIL rbw_gnt got %b expected 0011", bus.gnt); end
    advance();
    c_req[0] = 1'b0;
    drive();
    sample();
    n_chk++; if (bus.rvalid !== 4'b0010) begin n_err++; $display("FAIL rbw_rvalid got %b expected 0010", bus.rvalid); end
    n_chk++; if (bus.rdata[1*DW +: DW] !== 8'h00) begin n_err++; $display("FAIL rbw_old_word got %h expected 00", bus.rdata[1*DW +: DW]); end
    advance();
    clear_reqs();
    sample();
    n_chk++; if (bus.rdata[1*DW +: DW] !== 8'h77) begin n_err++; $display("FAIL rbw_new_word got %h expected 77", bus.rdata[1*DW +: DW]); end
    advance();
  endtask

  task automatic test_reset_mid_read();
    set_client(2, 1'b1, 1'b0, 6'd5, '0);
    drive();
    sample();
    n_chk++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL midrst_gnt got %b expected 0100", bus.gnt); end
    advance();
    rst = 1'b0;
    model_reset();
    clear_reqs();
    for (int k = 0; k < 4; k++) begin
      sample();
      n_chk++; if (bus.rvalid !== 4'b0000) begin n_err++; $display("FAIL midrst_rvalid cycle %0d got %b expected 0000", k, bus.rvalid); end
      advance();
      rst = 1'b1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (!c_req[i]) set_client(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                  AW'($urandom_range(0, 7)), DW'($urandom));
      end
      drive();
      sample();
      n_chk++; if (bus.gnt !== e_gnt) begin n_err++; $display("FAIL rand_gnt cycle %0d got %b expected %b", k, bus.gnt, e_gnt); end
      n_chk++; if (bus.rvalid !== e_rvalid) begin n_err++; $display("FAIL rand_rvalid cycle %0d got %b expected %b", k, bus.rvalid, e_rvalid); end
      for (int i = 0; i < NR; i++) begin
        if (e_chk[i]) begin
          n_chk++; if (bus.rdata[i*DW +: DW] !== e_rdata[i]) begin n_err++; $display("FAIL rand_rdata cycle %0d client %0d got %h expected %h", k, i, bus.rdata[i*DW +: DW], e_rdata[i]); end
        end
      end
      n_chk++; if ({bus.ram_wen_a, bus.ram_waddr_a, bus.ram_raddr_a, bus.ram_wdata_a} !== {e_wen[0], e_waddr[0], e_raddr[0], e_wdata[0]})
        begin n_err++; $display("FAIL rand_port_a cycle %0d got %b/%h/%h/%h expected %b/%h/%h/%h", k, bus.ram_wen_a, bus.ram_waddr_a, bus.ram_raddr_a, bus.ram_wdata_a, e_wen[0], e_waddr[0], e_raddr[0], e_wdata[0]); end
      n_chk++; if ({bus.ram_wen_b, bus.ram_waddr_b, bus.ram_raddr_b, bus.ram_wdata_b} !== {e_wen[1], e_waddr[1], e_raddr[1], e_wdata[1]})
        begin n_err++; $display("FAIL rand_port_b cycle %0d got %b/%h/%h/%h expected %b/%h/%h/%h", k, bus.ram_wen_b, bus.ram_waddr_b, bus.ram_raddr_b, bus.ram_wdata_b, e_wen[1], e_waddr[1], e_raddr[1], e_wdata[1]); end
      for (int i = 0; i < NR; i++) begin
        if (bus.gnt[i] === 1'b1) begin
          n_chk++; if (wait_cnt[i] > NR - 1) begin n_err++; $display("FAIL rand_fairness client %0d waited %0d cycles, limit %0d", i, wait_cnt[i], NR - 1); end
          wait_cnt[i] = 0;
        end else if (c_req[i]) begin
          wait_cnt[i]++;
        end
      end
      advance();
      for (int i = 0; i < NR; i++) if (e_gnt[i]) c_req[i] = 1'b0;
    end
    clear_reqs();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) set_client(i, 1'b0, 1'b0, '0, '0);
    drive();
    test_reset();
    test_write_read();
    test_conflict();
    test_round_robin();
    test_read_before_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
